poly_ram_bank: RTL and testbench

Multi-bank true dual-port coefficient RAM for the Kyber datapath: NBANK independent banks of 2^DEPTH words × WIDTH bits, sharing two access ports with per-port bank select. Adds a selectable read pipeline (RD_LAT), a read-valid strobe, a defined cross-port collision rule and a built-in bank-clear sequencer that zeroes one bank while the other banks stay accessible. It sits between the NTT/poly arithmetic units and the hash/sampler front end, so one bank can be refilled while another is being processed.

---
 rtl/poly_ram_bank_if.sv | 29 ++
 rtl/poly_ram_bank.sv | 141 ++++++++++++++
 tb/tb_poly_ram_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_ram_bank_if.sv
// poly_ram_bank_if: two access ports plus bank-clear control for poly_ram_bank
interface poly_ram_bank_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int NBANK = 2
);
    localparam int BW = $clog2(NBANK);
    logic             en_1, en_2;
    logic             we_1, we_2;
    logic [BW-1:0]    bank_1, bank_2;
    logic [DEPTH-1:0] addr_1, addr_2;
    logic [WIDTH-1:0] din_1, din_2;
    logic [WIDTH-1:0] dout_1, dout_2;
    logic             valid_1, valid_2;
    logic             clr_start;
    logic [BW-1:0]    clr_bank;
    logic             clr_busy;
    logic             clr_done;
    modport master (
        output en_1, en_2, we_1, we_2, bank_1, bank_2, addr_1, addr_2, din_1, din_2,
        output clr_start, clr_bank,
        input  dout_1, dout_2, valid_1, valid_2, clr_busy, clr_done
    );
    modport slave (
        input  en_1, en_2, we_1, we_2, bank_1, bank_2, addr_1, addr_2, din_1, din_2,
        input  clr_start, clr_bank,
        output dout_1, dout_2, valid_1, valid_2, clr_busy, clr_done
    );
endinterface

// File: rtl/poly_ram_bank.sv
// poly_ram_bank: multi-bank dual-port coefficient RAM with read pipeline and bank-clear sequencer
module poly_ram_bank #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 16,
    parameter int NBANK  = 2,
    parameter int RD_LAT = 1
) (
    input logic            clk,
    input logic            rst,
    poly_ram_bank_if.slave bus
);
    localparam int BW    = $clog2(NBANK);
    localparam int WORDS = 1 << DEPTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-2:0] cnt_q, cnt_d;
    logic [BW-1:0]    cbank_q, cbank_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rd_1_q, rd_1_d, rd_2_q, rd_2_d;
    logic             vld_1_q, vld_1_d, vld_2_q, vld_2_d;
    logic [WIDTH-1:0] mem [NBANK][WORDS];
    logic             busy, start_ok, acc_1, acc_2, wr_1, wr_2, same_word;

    // Access acceptance: the bank under clear is locked from the start edge onward
    always_comb begin
        busy      = (state_q == CLEAR);
        start_ok  = bus.clr_start && !busy;
        acc_1     = bus.en_1 && !((busy && bus.bank_1 == cbank_q) ||
                                  (start_ok && bus.bank_1 == bus.clr_bank));
        acc_2     = bus.en_2 && !((busy && bus.bank_2 == cbank_q) ||
                                  (start_ok && bus.bank_2 == bus.clr_bank));
        wr_1      = acc_1 && bus.we_1;
        wr_2      = acc_2 && bus.we_2;
        same_word = (bus.bank_1 == bus.bank_2) && (bus.addr_1 == bus.addr_2);
    end

    // First read stage: write-first on own port, read-first across ports, port 1 wins a double write
    always_comb begin
        rd_1_d  = acc_1 ? (bus.we_1 ? bus.din_1 : mem[bus.bank_1][bus.addr_1]) : rd_1_q;
        rd_2_d  = acc_2 ? (bus.we_2 ? ((wr_1 && same_word) ? bus.din_1 : bus.din_2)
                                    : mem[bus.bank_2][bus.addr_2]) : rd_2_q;
        vld_1_d = acc_1;
        vld_2_d = acc_2;
    end

    // Clear sequencer next state: two words zeroed per cycle over the latched bank
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cbank_d = cbank_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.clr_start) begin
                state_d = CLEAR;
                cbank_d = bus.clr_bank;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Control and first-stage read registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cbank_q <= '0;
            done_q  <= 1'b0;
            rd_1_q  <= '0;
            rd_2_q  <= '0;
            vld_1_q <= 1'b0;
            vld_2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cbank_q <= cbank_d;
            done_q  <= done_d;
            rd_1_q  <= rd_1_d;
            rd_2_q  <= rd_2_d;
            vld_1_q <= vld_1_d;
            vld_2_q <= vld_2_d;
        end
    end

    // Storage array: clear writes first, then port 2, then port 1 so port 1 takes a collision
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cbank_q][{cnt_q, 1'b0}] <= '0;
            mem[cbank_q][{cnt_q, 1'b1}] <= '0;
        end
        if (wr_2) mem[bus.bank_2][bus.addr_2] <= bus.din_2;
        if (wr_1) mem[bus.bank_1][bus.addr_1] <= bus.din_1;
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] out_1_q, out_1_d, out_2_q, out_2_d;
            logic             ov_1_q, ov_1_d, ov_2_q, ov_2_d;
            // Extra output stage keeps data and valid aligned
            always_comb begin
                out_1_d = rd_1_q;
                out_2_d = rd_2_q;
                ov_1_d  = vld_1_q;
                ov_2_d  = vld_2_q;
            end
            // Second read stage registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_1_q <= '0;
                    out_2_q <= '0;
                    ov_1_q  <= 1'b0;
                    ov_2_q  <= 1'b0;
                end else begin
                    out_1_q <= out_1_d;
                    out_2_q <= out_2_d;
                    ov_1_q  <= ov_1_d;
                    ov_2_q  <= ov_2_d;
                end
            end
            assign bus.dout_1  = out_1_q;
            assign bus.dout_2  = out_2_q;
            assign bus.valid_1 = ov_1_q;
            assign bus.valid_2 = ov_2_q;
        end else begin : g_lat1
            assign bus.dout_1  = rd_1_q;
            assign bus.dout_2  = rd_2_q;
            assign bus.valid_1 = vld_1_q;
            assign bus.valid_2 = vld_2_q;
        end
    endgenerate

    assign bus.clr_busy = busy;
    assign bus.clr_done = done_q;
endmodule

// File: tb/tb_poly_ram_bank.sv
// tb_poly_ram_bank: randomized and directed checks of both read latencies against a word-level model
module tb_poly_ram_bank;
    localparam int WORDS = 256;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    poly_ram_bank_if #(.DEPTH(8), .WIDTH(16), .NBANK(2)) bus1 ();
    poly_ram_bank_if #(.DEPTH(8), .WIDTH(16), .NBANK(2)) bus2 ();

    assign bus2.en_1      = bus1.en_1;
    assign bus2.en_2      = bus1.en_2;
    assign bus2.we_1      = bus1.we_1;
    assign bus2.we_2      = bus1.we_2;
    assign bus2.bank_1    = bus1.bank_1;
    assign bus2.bank_2    = bus1.bank_2;
    assign bus2.addr_1    = bus1.addr_1;
    assign bus2.addr_2    = bus1.addr_2;
    assign bus2.din_1     = bus1.din_1;
    assign bus2.din_2     = bus1.din_2;
    assign bus2.clr_start = bus1.clr_start;
    assign bus2.clr_bank  = bus1.clr_bank;

    poly_ram_bank #(.DEPTH(8), .WIDTH(16), .NBANK(2), .RD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    poly_ram_bank #(.DEPTH(8), .WIDTH(16), .NBANK(2), .RD_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // model: memory words, clear progress in words, expected outputs per latency [lat][port]
    logic [15:0] mm [2][WORDS];
    bit          busy_m, done_m;
    int          cb_m, cnt_m;
    logic [15:0] ed [2][2];
    bit          ev [2][2];
    bit          ek [2][2];

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit          start_ok;
        bit          acc [2];
        bit          en [2];
        bit          we [2];
        int          bk [2];
        int          ad [2];
        logic [15:0] dn [2];
        en = '{bus1.en_1, bus1.en_2};
        we = '{bus1.we_1, bus1.we_2};
        bk = '{int'(bus1.bank_1), int'(bus1.bank_2)};
        ad = '{int'(bus1.addr_1), int'(bus1.addr_2)};
        dn = '{bus1.din_1, bus1.din_2};
        ed[1] = ed[0];
        ev[1] = ev[0];
        ek[1] = ek[0];
        start_ok = bus1.clr_start && !busy_m;
        for (int p = 0; p < 2; p++) begin
            acc[p] = en[p] && !((busy_m && bk[p] == cb_m) || (start_ok && bk[p] == int'(bus1.clr_bank)));
            if (acc[p]) begin
                ev[0][p] = 1'b1;
                ek[0][p] = 1'b1;
                ed[0][p] = we[p] ? dn[p] : mm[bk[p]][ad[p]];
            end else begin
                ev[0][p] = 1'b0;
                if (en[p]) ek[0][p] = 1'b0;
            end
        end
        if (acc[0] && we[0] && acc[1] && we[1] && bk[0] == bk[1] && ad[0] == ad[1]) ed[0][1] = dn[0];
        if (acc[1] && we[1]) mm[bk[1]][ad[1]] = dn[1];
        if (acc[0] && we[0]) mm[bk[0]][ad[0]] = dn[0];
        done_m = 1'b0;
        if (busy_m) begin
            mm[cb_m][cnt_m]     = 16'h0;
            mm[cb_m][cnt_m + 1] = 16'h0;
            cnt_m += 2;
            if (cnt_m == WORDS) begin
                busy_m = 1'b0;
                done_m = 1'b1;
            end
        end else if (start_ok) begin
            busy_m = 1'b1;
            cb_m   = int'(bus1.clr_bank);
            cnt_m  = 0;
        end
    endtask

    task automatic compare();
        chk("L1 valid_1", bus1.valid_1, ev[0][0]);
        chk("L1 valid_2", bus1.valid_2, ev[0][1]);
        if (ek[0][0]) chk("L1 dout_1", bus1.dout_1, ed[0][0]);
        if (ek[0][1]) chk("L1 dout_2", bus1.dout_2, ed[0][1]);
        chk("L2 valid_1", bus2.valid_1, ev[1][0]);
        chk("L2 valid_2", bus2.valid_2, ev[1][1]);
        if (ek[1][0]) chk("L2 dout_1", bus2.dout_1, ed[1][0]);
        if (ek[1][1]) chk("L2 dout_2", bus2.dout_2, ed[1][1]);
        chk("L1 clr_busy", bus1.clr_busy, busy_m);
        chk("L1 clr_done", bus1.clr_done, done_m);
        chk("L2 clr_busy", bus2.clr_busy, busy_m);
        chk("L2 clr_done", bus2.clr_done, done_m);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        bus1.en_1 = 0; bus1.en_2 = 0; bus1.we_1 = 0; bus1.we_2 = 0;
        bus1.bank_1 = 0; bus1.bank_2 = 0; bus1.addr_1 = 0; bus1.addr_2 = 0;
        bus1.din_1 = 0; bus1.din_2 = 0; bus1.clr_start = 0; bus1.clr_bank = 0;
    endtask

    task automatic port(int p, bit en, bit we, int bank, int addr, logic [15:0] din);
        if (p == 1) begin
            bus1.en_1 = en; bus1.we_1 = we; bus1.bank_1 = 1'(bank); bus1.addr_1 = 8'(addr); bus1.din_1 = din;
        end else begin
            bus1.en_2 = en; bus1.we_2 = we; bus1.bank_2 = 1'(bank); bus1.addr_2 = 8'(addr); bus1.din_2 = din;
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        busy_m = 1'b0;
        done_m = 1'b0;
        for (int l = 0; l < 2; l++)
            for (int p = 0; p < 2; p++) begin
                ed[l][p] = 16'h0; ev[l][p] = 1'b0; ek[l][p] = 1'b1;
            end
        compare();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
    endtask

    initial begin
        int busy_n, dones, nz, g;
        do_reset();
        // preload every word so later random reads are defined
        for (int a = 0; a < WORDS; a++) begin
            port(1, 1, 1, 0, a, 16'($urandom));
            port(2, 1, 1, 1, a, 16'($urandom));
            step();
        end
        // basic write then read, both latencies
        idle(); port(1, 1, 1, 0, 5, 16'h0ABC); step();
        idle(); port(2, 1, 0, 0, 5, 16'h0); step();
        chk("basic L1 dout_2", bus1.dout_2, 16'h0ABC);
        chk("basic L1 valid_2", bus1.valid_2, 16'h1);
        idle(); step();
        chk("basic L2 dout_2", bus2.dout_2, 16'h0ABC);
        chk("basic L2 valid_2", bus2.valid_2, 16'h1);
        // bank isolation
        idle(); port(1, 1, 1, 0, 3, 16'h1111); port(2, 1, 1, 1, 3, 16'h2222); step();
        idle(); port(1, 1, 0, 1, 3, 16'h0); port(2, 1, 0, 0, 3, 16'h0); step();
        chk("iso dout_1", bus1.dout_1, 16'h2222);
        chk("iso dout_2", bus1.dout_2, 16'h1111);
        // write/write collision: port 1 wins
        idle(); port(1, 1, 1, 1, 7, 16'h0001); port(2, 1, 1, 1, 7, 16'h0002); step();
        chk("ww dout_2", bus1.dout_2, 16'h0001);
        idle(); port(2, 1, 0, 1, 7, 16'h0); step();
        chk("ww readback", bus1.dout_2, 16'h0001);
        // write/read collision: reader sees old word
        idle(); port(1, 1, 1, 0, 9, 16'h0033); step();
        port(1, 1, 1, 0, 9, 16'h0055); port(2, 1, 0, 0, 9, 16'h0); step();
        chk("wr old dout_2", bus1.dout_2, 16'h0033);
        chk("wr own dout_1", bus1.dout_1, 16'h0055);
        idle(); port(2, 1, 0, 0, 9, 16'h0); step();
        chk("wr readback", bus1.dout_2, 16'h0055);
        // random traffic with occasional clears, narrow address range to force collisions
        for (int i = 0; i < 600; i++) begin
            port(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                 $urandom_range(0, 15), 16'($urandom));
            port(2, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                 $urandom_range(0, 15), 16'($urandom));
            bus1.clr_start = ($urandom_range(0, 99) == 0);
            bus1.clr_bank  = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        g = 0;
        while (busy_m && g < 300) begin step(); g++; end
        // fill bank 1 then clear it while bank 0 stays in use
        for (int a = 0; a < WORDS / 2; a++) begin
            port(1, 1, 1, 1, 2 * a, 16'hFFFF); port(2, 1, 1, 1, 2 * a + 1, 16'hFFFF); step();
        end
        idle(); bus1.clr_start = 1; bus1.clr_bank = 1; step();
        chk("clr_busy rise", bus1.clr_busy, 16'h1);
        busy_n = 0;
        dones = 0;
        while (bus1.clr_busy && busy_n < 300) begin
            busy_n++;
            port(1, 1, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 31), 16'($urandom));
            port(2, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 1), $urandom_range(0, 31), 16'($urandom));
            bus1.clr_start = (busy_n == 50);
            bus1.clr_bank  = 0;
            step();
            if (bus1.clr_done) dones++;
        end
        chk("busy cycles", 16'(busy_n), 16'd128);
        chk("done pulses", 16'(dones), 16'd1);
        chk("done at end", bus1.clr_done, 16'h1);
        // restart in the clr_done cycle, read bank 1 back while bank 0 clears
        idle(); bus1.clr_start = 1; bus1.clr_bank = 0; step();
        chk("restart busy", bus1.clr_busy, 16'h1);
        nz = 0;
        for (int a = 0; a < WORDS / 2; a++) begin
            idle(); port(1, 1, 0, 1, 2 * a, 16'h0); port(2, 1, 0, 1, 2 * a + 1, 16'h0); step();
            if (bus1.dout_1 !== 16'h0 || bus1.dout_2 !== 16'h0) nz++;
        end
        chk("bank1 zero words", 16'(nz), 16'd0);
        idle();
        g = 0;
        while (bus1.clr_busy && g < 300) begin step(); g++; end
        chk("second clear ends", bus1.clr_busy, 16'h0);
        // reset during clear: only the first 80 words get zeroed
        for (int a = 0; a < WORDS / 2; a++) begin
            port(1, 1, 1, 0, 2 * a, 16'hC000 | 16'(2 * a));
            port(2, 1, 1, 0, 2 * a + 1, 16'hC000 | 16'(2 * a + 1));
            step();
        end
        idle(); bus1.clr_start = 1; bus1.clr_bank = 0; step();
        idle();
        repeat (40) step();
        do_reset();
        chk("rst busy", bus1.clr_busy, 16'h0);
        for (int a = 0; a < WORDS / 2; a++) begin
            port(1, 1, 0, 0, 2 * a, 16'h0); port(2, 1, 0, 0, 2 * a + 1, 16'h0); step();
            if (a == 39) chk("addr79 cleared", bus1.dout_2, 16'h0);
            if (a == 40) chk("addr80 kept", bus1.dout_1, 16'hC050);
        end
        idle();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
